// File: rtl/satatrn_pkg.sv
// satatrn_pkg: shared constants and FSM state type for the SATA transport TX mux.
// Provides the DATA FIS type byte, default split size and the mux state enum.
package satatrn_pkg;

    localparam logic [7:0] FIS_DATA  = 8'h46;
    localparam int         MAXDW_DEF = 2048;
    localparam int         CNTW      = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY
    } state_t;

endpackage

// File: rtl/satatrn_rrarb.sv
// satatrn_rrarb: combinational round-robin picker.
// Ports: i_req request vector, i_ptr last grant; o_grant one-hot, o_idx index,
// o_any set when some request was found. Search starts at i_ptr+1 mod NSRC.
module satatrn_rrarb #(
    parameter int NSRC = 2,
    parameter int SW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0] i_req,
    input  logic [SW-1:0]   i_ptr,
    output logic [NSRC-1:0] o_grant,
    output logic [SW-1:0]   o_idx,
    output logic            o_any
);

    logic          w_hit;
    logic [SW-1:0] w_idx;

    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = 1; i <= NSRC; i++) begin
            if (!w_hit && i_req[SW'((int'(i_ptr) + i) % NSRC)]) begin
                w_hit = 1'b1;
                w_idx = SW'((int'(i_ptr) + i) % NSRC);
            end
        end
    end

    always_comb begin
        o_grant = '0;
        if (w_hit) begin
            o_grant[w_idx] = 1'b1;
        end
    end

    assign o_idx = w_idx;
    assign o_any = w_hit;

endmodule

// File: rtl/satatrn_txmux.sv
// satatrn_txmux: round-robin N-source packet mux for the SATA transport TX path.
// Ports: i_phy_clk/i_phy_reset_n (async active-low), per-source i_gate, i_valid,
// o_ready, i_data (source k at [k*DW +: DW]), i_last; link side o_valid, i_ready,
// o_data, o_last, o_src. Header-mode sources (HDRMASK) get a 0x46 header word.
// Optional macro SATATRN_TXMUX_SPLIT_EN splits data FISes longer than MAXDW words.
module satatrn_txmux
    import satatrn_pkg::*;
#(
    parameter int              NSRC         = 2,
    parameter int              DW           = 32,
    parameter logic [NSRC-1:0] HDRMASK      = NSRC'(2),
    parameter int              MAXDW        = MAXDW_DEF,
    parameter bit              OPT_LOWPOWER = 1'b0,
    localparam int             SW           = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic               i_phy_clk,
    input  logic               i_phy_reset_n,
    input  logic [NSRC-1:0]    i_gate,
    input  logic [NSRC-1:0]    i_valid,
    output logic [NSRC-1:0]    o_ready,
    input  logic [NSRC*DW-1:0] i_data,
    input  logic [NSRC-1:0]    i_last,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DW-1:0]      o_data,
    output logic               o_last,
    output logic [SW-1:0]      o_src
);

    localparam logic [DW-1:0] HDR_WORD = {FIS_DATA, {(DW-8){1'b0}}};

    if (NSRC < 2 || NSRC > 8 || DW < 16 || MAXDW < 1 || MAXDW > 4096
        || (MAXDW & (MAXDW - 1)) != 0) begin : g_bad_cfg
        $error("satatrn_txmux: illegal NSRC/DW/MAXDW");
    end

    state_t          r_state;
    state_t          w_nx_state;
    logic            r_valid;
    logic            r_last;
    logic [DW-1:0]   r_data;
    logic [SW-1:0]   r_src;
    logic [SW-1:0]   r_ptr;
    logic            w_nx_valid;
    logic            w_nx_last;
    logic [DW-1:0]   w_nx_data;
    logic [SW-1:0]   w_nx_src;
    logic [SW-1:0]   w_nx_ptr;
    logic [NSRC-1:0] w_ready;
    logic [NSRC-1:0] w_elig;
    logic [NSRC-1:0] w_gnt_oh;
    logic [SW-1:0]   w_gnt;
    logic            w_any;
    logic            w_adv;
    logic [DW-1:0]   w_cur_data;
    logic            w_cur_valid;
    logic            w_cur_last;
`ifdef SATATRN_TXMUX_SPLIT_EN
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_nx_cnt;
`endif

    assign w_adv  = !r_valid || i_ready;
    // Gate matters only for header-mode sources, and only when arbitrating.
    assign w_elig = i_valid & (~HDRMASK | i_gate);

    satatrn_rrarb #(
        .NSRC (NSRC),
        .SW   (SW)
    ) u_arb (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt_oh),
        .o_idx   (w_gnt),
        .o_any   (w_any)
    );

    // r_ptr holds the granted source for the whole packet.
    assign w_cur_data  = i_data[int'(r_ptr)*DW +: DW];
    assign w_cur_valid = i_valid[r_ptr];
    assign w_cur_last  = i_last[r_ptr];

    always_comb begin
        w_nx_state = r_state;
        w_nx_valid = r_valid;
        w_nx_last  = r_last;
        w_nx_data  = r_data;
        w_nx_src   = r_src;
        w_nx_ptr   = r_ptr;
        w_ready    = '0;
`ifdef SATATRN_TXMUX_SPLIT_EN
        w_nx_cnt   = r_cnt;
`endif
        if (w_adv) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_any) begin
                        w_nx_valid = 1'b0;
                        w_nx_last  = 1'b0;
                    end else begin
                        w_nx_src   = w_gnt;
                        w_nx_ptr   = w_gnt;
                        w_nx_valid = 1'b1;
                        if (HDRMASK[w_gnt]) begin
                            w_nx_data  = HDR_WORD;
                            w_nx_last  = 1'b0;
                            w_nx_state = ST_BODY;
`ifdef SATATRN_TXMUX_SPLIT_EN
                            w_nx_cnt   = '0;
`endif
                        end else begin
                            w_ready    = w_gnt_oh;
                            w_nx_data  = i_data[int'(w_gnt)*DW +: DW];
                            w_nx_last  = i_last[w_gnt];
                            w_nx_state = i_last[w_gnt] ? ST_IDLE : ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    w_ready[r_ptr] = 1'b1;
                    w_nx_valid     = w_cur_valid;
                    w_nx_data      = w_cur_data;
                    w_nx_last      = w_cur_valid && w_cur_last;
                    if (w_cur_valid) begin
                        if (w_cur_last) begin
                            w_nx_state = ST_IDLE;
                        end
`ifdef SATATRN_TXMUX_SPLIT_EN
                        else if (HDRMASK[r_ptr]) begin
                            // Word MAXDW without i_last closes this FIS early.
                            if (r_cnt == CNTW'(MAXDW - 1)) begin
                                w_nx_last  = 1'b1;
                                w_nx_state = ST_HDR;
                            end else begin
                                w_nx_cnt = r_cnt + 1'b1;
                            end
                        end
`endif
                    end
                end
`ifdef SATATRN_TXMUX_SPLIT_EN
                ST_HDR: begin
                    w_nx_valid = 1'b1;
                    w_nx_data  = HDR_WORD;
                    w_nx_last  = 1'b0;
                    w_nx_cnt   = '0;
                    w_nx_state = ST_BODY;
                end
`endif
                default: begin
                    w_nx_state = ST_IDLE;
                end
            endcase
        end
        if (OPT_LOWPOWER && !w_nx_valid) begin
            w_nx_data = '0;
            w_nx_last = 1'b0;
        end
    end

    always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
            r_ptr   <= SW'(NSRC - 1);
`ifdef SATATRN_TXMUX_SPLIT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_nx_state;
            r_valid <= w_nx_valid;
            r_last  <= w_nx_last;
            r_data  <= w_nx_data;
            r_src   <= w_nx_src;
            r_ptr   <= w_nx_ptr;
`ifdef SATATRN_TXMUX_SPLIT_EN
            r_cnt   <= w_nx_cnt;
`endif
        end
    end

    // Nothing may be consumed while the block is held in reset.
    assign o_ready = w_ready & {NSRC{i_phy_reset_n}};
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_src   = r_src;

endmodule

// File: tb/tb_satatrn_txmux.sv
// tb_satatrn_txmux: randomized bench with a packet-level reference model
// for satatrn_txmux (2 sources, source 1 header-mode).
module tb_satatrn_txmux;

    localparam int              NSRC    = 2;
    localparam int              DW      = 32;
    localparam int              SW      = 1;
    localparam int              MAXDW   = 4;
    localparam logic [NSRC-1:0] HDRMASK = 2'b10;
    localparam logic [DW-1:0]   HDR     = 32'h4600_0000;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic [NSRC-1:0]    i_gate  = '0;
    logic [NSRC-1:0]    i_valid = '0;
    logic [NSRC-1:0]    i_last  = '0;
    logic [NSRC*DW-1:0] i_data  = '0;
    logic               i_ready = 1'b0;
    logic [NSRC-1:0]    o_ready;
    logic               o_valid;
    logic               o_last;
    logic [DW-1:0]      o_data;
    logic [SW-1:0]      o_src;

    always #5 clk = ~clk;

    satatrn_txmux #(
        .NSRC         (NSRC),
        .DW           (DW),
        .HDRMASK      (HDRMASK),
        .MAXDW        (MAXDW),
        .OPT_LOWPOWER (1'b0)
    ) dut (
        .i_phy_clk     (clk),
        .i_phy_reset_n (rst_n),
        .i_gate        (i_gate),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .i_last        (i_last),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_last        (o_last),
        .o_src         (o_src)
    );

    int n_vec = 0;
    int n_err = 0;

    // Per-source packet words waiting to be sent: {last, data}.
    logic [DW:0]      sq[NSRC][$];
    // Accepted output words: {src, last, data}.
    logic [SW+DW:0]   olog[$];

    int p_valid = 100;
    int p_ready = 100;
    int p_gate  = 100;

    // Reference model: expected output registers plus packet-level state.
    logic          e_valid;
    logic          e_last;
    logic [DW-1:0] e_data;
    int            e_src;
    int            rr;
    int            cur;
    bit            need_hdr;
    int            cnt;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [SW+DW:0] mk(input int s, input bit l,
                                          input logic [DW-1:0] d);
        logic [SW-1:0] s_w;
        s_w = s[SW-1:0];
        return {s_w, l, d};
    endfunction

    function automatic bit busy();
        bit b;
        b = (cur >= 0) || need_hdr;
        for (int k = 0; k < NSRC; k++) begin
            if (sq[k].size() > 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic mreset();
        e_valid  = 1'b0;
        e_last   = 1'b0;
        e_data   = '0;
        e_src    = 0;
        rr       = NSRC - 1;
        cur      = -1;
        need_hdr = 1'b0;
        cnt      = 0;
    endtask

    task automatic add_pkt(input int k, input logic [DW-1:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            sq[k].push_back({(i == len - 1), base + DW'(i)});
        end
    endtask

    task automatic cycle();
        logic [NSRC-1:0] m_ready;
        logic            nv;
        logic            nl;
        logic [DW-1:0]   nd;
        int              ns;
        int              g;
        bit              adv;
        @(negedge clk);
        chk("o_valid", o_valid, e_valid);
        if (e_valid) begin
            chk("o_data", o_data, e_data);
            chk("o_last", o_last, e_last);
            chk("o_src", o_src, e_src);
        end
        for (int k = 0; k < NSRC; k++) begin
            if (sq[k].size() > 0) begin
                i_valid[k]          = ($urandom_range(99) < p_valid);
                i_data[k*DW +: DW]  = sq[k][0][DW-1:0];
                i_last[k]           = sq[k][0][DW];
            end else begin
                i_valid[k]          = 1'b0;
                i_data[k*DW +: DW]  = $urandom;
                i_last[k]           = $urandom_range(1);
            end
            i_gate[k] = ($urandom_range(99) < p_gate);
        end
        i_ready = ($urandom_range(99) < p_ready);
        #1;
        m_ready = '0;
        nv = e_valid;
        nl = e_last;
        nd = e_data;
        ns = e_src;
        adv = !e_valid || i_ready;
        if (adv) begin
            if (cur < 0 && !need_hdr) begin
                g = -1;
                for (int i = 1; i <= NSRC; i++) begin
                    int k = (rr + i) % NSRC;
                    if (g < 0 && i_valid[k] && (!HDRMASK[k] || i_gate[k])) g = k;
                end
                if (g < 0) begin
                    nv = 1'b0;
                    nl = 1'b0;
                end else begin
                    rr = g;
                    ns = g;
                    nv = 1'b1;
                    if (HDRMASK[g]) begin
                        nd  = HDR;
                        nl  = 1'b0;
                        cur = g;
                        cnt = 0;
                    end else begin
                        m_ready[g] = 1'b1;
                        nd  = i_data[g*DW +: DW];
                        nl  = i_last[g];
                        cur = i_last[g] ? -1 : g;
                    end
                end
            end else if (need_hdr) begin
                nv       = 1'b1;
                nd       = HDR;
                nl       = 1'b0;
                need_hdr = 1'b0;
                cnt      = 0;
            end else begin
                m_ready[cur] = 1'b1;
                nv = i_valid[cur];
                nd = i_data[cur*DW +: DW];
                nl = i_valid[cur] && i_last[cur];
                if (i_valid[cur]) begin
                    if (i_last[cur]) begin
                        cur = -1;
                    end
`ifdef SATATRN_TXMUX_SPLIT_EN
                    else if (HDRMASK[cur]) begin
                        cnt++;
                        if (cnt == MAXDW) begin
                            nl       = 1'b1;
                            need_hdr = 1'b1;
                        end
                    end
`endif
                end
            end
        end
        chk("o_ready", o_ready, m_ready);
        if (o_valid && i_ready) olog.push_back({o_src, o_last, o_data});
        for (int k = 0; k < NSRC; k++) begin
            if (m_ready[k] && i_valid[k] && sq[k].size() > 0) void'(sq[k].pop_front());
        end
        @(posedge clk);
        e_valid = nv;
        e_last  = nl;
        e_data  = nd;
        e_src   = ns;
    endtask

    task automatic drain(input int bound);
        int t;
        int pr;
        t = 0;
        while (busy() && t < bound) begin
            cycle();
            t++;
        end
        n_vec++;
        if (busy()) begin
            n_err++;
            $display("FAIL drain: still busy after %0d cycles, expected idle", t);
        end
        pr = p_ready;
        p_ready = 100;
        repeat (3) cycle();
        p_ready = pr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = '1;
        i_gate  = '1;
        i_ready = 1'b1;
        #1;
        chk("rst o_valid", o_valid, 0);
        chk("rst o_ready", o_ready, 0);
        chk("rst o_last", o_last, 0);
        chk("rst o_data", o_data, 0);
        chk("rst o_src", o_src, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst hold o_valid", o_valid, 0);
        i_valid = '0;
        rst_n   = 1'b1;
        for (int k = 0; k < NSRC; k++) sq[k].delete();
        mreset();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int l0;
        int l1;
        int exp_src[15] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
        mreset();
        do_reset();

        // Single non-header packet.
        add_pkt(0, 32'hA000_0000, 3);
        olog.delete();
        drain(100);
        chk("t1 count", olog.size(), 3);
        if (olog.size() == 3) begin
            chk("t1 w0", olog[0], mk(0, 1'b0, 32'hA000_0000));
            chk("t1 w1", olog[1], mk(0, 1'b0, 32'hA000_0001));
            chk("t1 w2", olog[2], mk(0, 1'b1, 32'hA000_0002));
        end

        // Header source blocked by gate, then released.
        p_gate = 0;
        add_pkt(1, 32'hB000_0000, 2);
        olog.delete();
        repeat (5) cycle();
        chk("t2 gated", olog.size(), 0);
        p_gate = 100;
        drain(100);
        chk("t2 count", olog.size(), 3);
        if (olog.size() == 3) begin
            chk("t2 hdr", olog[0], mk(1, 1'b0, 32'h4600_0000));
            chk("t2 w0", olog[1], mk(1, 1'b0, 32'hB000_0000));
            chk("t2 w1", olog[2], mk(1, 1'b1, 32'hB000_0001));
        end

        // Back-to-back alternation with no idle cycles.
        for (int p = 0; p < 3; p++) begin
            add_pkt(0, 32'hC000_0000 + DW'(p * 16), 2);
            add_pkt(1, 32'hD000_0000 + DW'(p * 16), 2);
        end
        olog.delete();
        repeat (16) cycle();
        chk("t3 no gaps", olog.size(), 15);
        for (int i = 0; i < 15 && i < olog.size(); i++) begin
            chk("t3 src order", olog[i][SW+DW:DW+1], exp_src[i]);
        end
        drain(50);

        // Random back-pressure on 10-word packets.
        p_ready = 50;
        p_valid = 70;
        add_pkt(0, 32'h1000_0000, 10);
        add_pkt(1, 32'h2000_0000, 10);
        olog.delete();
        drain(1000);
        c0 = 0; c1 = 0; l0 = 0; l1 = 0;
        foreach (olog[i]) begin
            if (olog[i][SW+DW:DW+1] == 0) begin
                c0++;
                if (olog[i][DW]) l0++;
            end else begin
                c1++;
                if (olog[i][DW]) l1++;
            end
        end
        chk("t4 src0 words", c0, 10);
        chk("t4 src0 lasts", l0, 1);
`ifdef SATATRN_TXMUX_SPLIT_EN
        chk("t4 src1 words", c1, 13);
        chk("t4 src1 lasts", l1, 3);
`else
        chk("t4 src1 words", c1, 11);
        chk("t4 src1 lasts", l1, 1);
`endif

        // Randomized traffic.
        p_ready = 70;
        p_valid = 80;
        p_gate  = 60;
        for (int p = 0; p < 200; p++) begin
            add_pkt($urandom_range(NSRC - 1), DW'(p) << 8, $urandom_range(1, 12));
        end
        drain(20000);
        p_ready = 100;
        p_valid = 100;
        p_gate  = 100;

`ifdef SATATRN_TXMUX_SPLIT_EN
        // Oversize data FIS split at MAXDW.
        add_pkt(1, 32'hE000_0000, 6);
        olog.delete();
        drain(100);
        chk("t6 count", olog.size(), 8);
        if (olog.size() == 8) begin
            chk("t6 hdr0", olog[0], mk(1, 1'b0, 32'h4600_0000));
            chk("t6 w0", olog[1], mk(1, 1'b0, 32'hE000_0000));
            chk("t6 w3", olog[4], mk(1, 1'b1, 32'hE000_0003));
            chk("t6 hdr1", olog[5], mk(1, 1'b0, 32'h4600_0000));
            chk("t6 w4", olog[6], mk(1, 1'b0, 32'hE000_0004));
            chk("t6 w5", olog[7], mk(1, 1'b1, 32'hE000_0005));
        end
`endif

        // Reset in the middle of a packet.
        add_pkt(0, 32'hF000_0000, 8);
        repeat (3) cycle();
        do_reset();
        add_pkt(0, 32'h5000_0000, 2);
        add_pkt(1, 32'h6000_0000, 2);
        olog.delete();
        drain(100);
        chk("t7 count", olog.size(), 5);
        if (olog.size() > 0) begin
            chk("t7 first", olog[0], mk(0, 1'b0, 32'h5000_0000));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
